// File: rtl/mux41_rr_sched_pkg.sv
// Shared constants, FSM encoding and arbitration helpers for the
// round-robin 4:1 mux scheduler.
package mux41_rr_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Round-robin pick: first set bit of (req & ~excl), searching from ptr upward
  // with wrap. Returns a one-hot vector, or zero when nobody is eligible.
  function automatic logic [NUM_REQ-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [SEL_W-1:0]   ptr,
    input logic [NUM_REQ-1:0] excl
  );
    logic [NUM_REQ-1:0] cand;
    logic [SEL_W-1:0]   idx;
    logic               found;
    rr_pick = '0;
    cand    = req & ~excl;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + k[SEL_W-1:0];
      if (!found && cand[idx]) begin
        rr_pick[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  endfunction

  // One-hot to binary; a zero input yields zero.
  function automatic logic [SEL_W-1:0] oh2bin(input logic [NUM_REQ-1:0] oh);
    oh2bin = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (oh[k]) oh2bin = oh2bin | k[SEL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mux41_rr_sched_mux41structural.sv
// Gate-level 4:1 multiplexer: c = a[s].
module mux41structural (
  input  logic [3:0] a,
  input  logic [1:0] s,
  output logic       c
);

  logic [3:0] term;

  assign term[0] = a[0] & ~s[1] & ~s[0];
  assign term[1] = a[1] & ~s[1] &  s[0];
  assign term[2] = a[2] &  s[1] & ~s[0];
  assign term[3] = a[3] &  s[1] &  s[0];
  assign c       = |term;

endmodule

// File: rtl/mux41_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux among four requesters, with
// burst-limited grants and a registered, valid-qualified mux output.
module mux41_rr_sched
  import mux41_rr_sched_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] a,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   s,
  output logic               busy,
  output logic               c_q,
  output logic               vld_q
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic               c_d, vld_d;
  logic               c;
  logic               rel;
  logic [NUM_REQ-1:0] excl;
  logic [NUM_REQ-1:0] win;

  // Shared mux; select comes straight from the registered grant encoding.
  mux41structural u_mux (
    .a (a),
    .s (s_q),
    .c (c)
  );

  // Arbitration: grant from idle, or release and re-arbitrate on the same edge.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    rel     = 1'b0;
    excl    = '0;
    win     = '0;
    case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          win     = rr_pick(req, ptr_q, '0);
          state_d = ST_GRANT;
          gnt_d   = win;
          s_d     = oh2bin(win);
          cnt_d   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        // s_q is the holder index while a grant is held.
        rel = !req[s_q] || (cnt_q == CNT_W'(MAX_BURST));
        if (rel) begin
          ptr_d = s_q + 2'd1;
          excl  = req[s_q] ? '0 : (NUM_REQ'(1) << s_q);
          // Search starts after the holder, so an expired holder only wins
          // again when it is the sole requester.
          win   = rr_pick(req, s_q + 2'd1, excl);
          if (win != '0) begin
            gnt_d = win;
            s_d   = oh2bin(win);
            cnt_d = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output capture: follow the mux while granted, otherwise hold.
  always_comb begin
    c_d   = busy ? c : c_q;
    vld_d = busy;
  end

  // State registers; reset also discards any in-flight output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt  = gnt_q;
  assign s    = s_q;
  assign busy = |gnt_q;

endmodule
